despawn: RTL and testbench

DESPAWN -- requirements
Module: despawn

---
 rtl/despawn.sv | 108 ++++++++++
 tb/tb_despawn.sv | 110 +++++++++++
 2 files changed

// File: rtl/despawn.sv
// despawn: glides an object from its current offset to a fixed exit point in 2^STEP_LOG2 ticked steps.
// Define DESPAWN_FADE_EN to add a 4-bit alpha output that fades out during the move.
module despawn #(
  parameter int HWIDTH = 11,
  parameter int VWIDTH = 11,
  parameter logic signed [HWIDTH-1:0] HDST = 640,
  parameter logic signed [VWIDTH-1:0] VDST = 0,
  parameter int STEP_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     tick,
  input  logic signed [HWIDTH-1:0] hcur,
  input  logic signed [VWIDTH-1:0] vcur,
  output logic signed [HWIDTH-1:0] hoffset,
  output logic signed [VWIDTH-1:0] voffset,
  output logic                     busy,
  output logic                     done,
  output logic                     visible
`ifdef DESPAWN_FADE_EN
  ,
  output logic [3:0]               alpha
`endif
);
  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;
  state_t                 state_q;
  logic signed [HWIDTH-1:0] hoff_q, hdel_q, hdel_d, hsum_d;
  logic signed [VWIDTH-1:0] voff_q, vdel_q, vdel_d, vsum_d;
  logic signed [HWIDTH:0]   hdif_d;
  logic signed [VWIDTH:0]   vdif_d;
  logic [STEP_LOG2-1:0]     step_q;
  logic                     busy_q, done_q, visible_q;
`ifdef DESPAWN_FADE_EN
  logic [3:0]               alpha_q;
`endif
  // One extra bit keeps the distance exact before the arithmetic shift; the shifted result always fits back in width.
  assign hdif_d = {HDST[HWIDTH-1], HDST} - {hcur[HWIDTH-1], hcur};
  assign vdif_d = {VDST[VWIDTH-1], VDST} - {vcur[VWIDTH-1], vcur};
  assign hdel_d = HWIDTH'(hdif_d >>> STEP_LOG2);
  assign vdel_d = VWIDTH'(vdif_d >>> STEP_LOG2);
  assign hsum_d = hoff_q + hdel_q;
  assign vsum_d = voff_q + vdel_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hoff_q    <= '0;
      voff_q    <= '0;
      hdel_q    <= '0;
      vdel_q    <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      visible_q <= 1'b1;
`ifdef DESPAWN_FADE_EN
      alpha_q   <= 4'd15;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= MOVE;
          hoff_q    <= hcur;
          voff_q    <= vcur;
          hdel_q    <= hdel_d;
          vdel_q    <= vdel_d;
          step_q    <= '0;
          busy_q    <= 1'b1;
          visible_q <= 1'b1;
`ifdef DESPAWN_FADE_EN
          alpha_q   <= 4'd15;
`endif
        end
        MOVE: if (tick) begin
          // The final step snaps to the exit point so truncated deltas leave no residue.
          if (&step_q) begin
            state_q   <= DONE;
            hoff_q    <= HDST;
            voff_q    <= VDST;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            visible_q <= 1'b0;
`ifdef DESPAWN_FADE_EN
            alpha_q   <= 4'd0;
`endif
          end else begin
            hoff_q <= hsum_d;
            voff_q <= vsum_d;
            step_q <= step_q + 1'b1;
`ifdef DESPAWN_FADE_EN
            alpha_q <= (alpha_q == 4'd0) ? 4'd0 : alpha_q - 4'd1;
`endif
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign hoffset = hoff_q;
  assign voffset = voff_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign visible = visible_q;
`ifdef DESPAWN_FADE_EN
  assign alpha   = alpha_q;
`endif
endmodule

// File: tb/tb_despawn.sv
// tb_despawn: scoreboard bench for despawn with default parameters.
module tb_despawn;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tick = 1'b0;
  logic signed [10:0] hcur = '0, vcur = '0;
  logic signed [10:0] hoffset, voffset;
  logic busy, done, visible;
  int checks = 0, errors = 0;
  int hq[$], vq[$];
  despawn dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .hcur(hcur), .vcur(vcur), .hoffset(hoffset), .voffset(voffset),
    .busy(busy), .done(done), .visible(visible)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic st, input logic tk);
    start = st;
    tick = tk;
    @(posedge clk);
    #1;
    start = 1'b0;
    tick = 1'b0;
  endtask
  task automatic run_move(input int hc, input int vc, input int gap, input bit same, input bit poke, input int rst_at);
    logic signed [10:0] he, ve;
    int hd, vd, ho, vo;
    hd = (640 - hc) >>> 3;
    vd = (0 - vc) >>> 3;
    he = 11'(hc);
    ve = 11'(vc);
    hcur = 11'(hc);
    vcur = 11'(vc);
    cyc(1'b1, same);
    check("cap_h", hoffset, he);
    check("cap_v", voffset, ve);
    check("cap_busy", busy, 1);
    check("cap_vis", visible, 1);
    for (int k = 1; k <= 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (poke && k == 3 && g == 0) begin
          hcur = 11'(-500);
          vcur = 11'(300);
          cyc(1'b1, 1'b0);
        end else cyc(1'b0, 1'b0);
        check("hold_h", hoffset, he);
        check("hold_v", voffset, ve);
      end
      he = (k == 8) ? 11'sd640 : 11'(he + hd);
      ve = (k == 8) ? 11'sd0 : 11'(ve + vd);
      hq.push_back(he);
      vq.push_back(ve);
      cyc(1'b0, 1'b1);
      ho = hq.pop_front();
      vo = vq.pop_front();
      check("step_h", hoffset, ho);
      check("step_v", voffset, vo);
      check("step_done", done, (k == 8) ? 1 : 0);
      check("step_busy", busy, (k == 8) ? 0 : 1);
      if (hc == 100 && k == 7) check("trunc_h", hoffset, 569);
      if (k == rst_at) begin
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        check("rst_h", hoffset, 0);
        check("rst_v", voffset, 0);
        check("rst_busy", busy, 0);
        check("rst_vis", visible, 1);
        check("rst_done", done, 0);
        cyc(1'b0, 1'b1);
        check("rst_nodone", done, 0);
        return;
      end
    end
    check("done_vis", visible, 0);
    hcur = 11'(-200);
    cyc(1'b1, 1'b0);
    check("post_done", done, 0);
    check("post_h", hoffset, 640);
    check("post_busy", busy, 0);
    check("post_vis", visible, 0);
  endtask
  initial begin
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset_h", hoffset, 0);
    check("reset_v", voffset, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_vis", visible, 1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    check("idle_busy", busy, 0);
    run_move(320, 240, 0, 1'b0, 1'b0, 0);
    run_move(100, 0, 1, 1'b0, 1'b0, 0);
    run_move(320, 240, 2, 1'b0, 1'b1, 0);
    run_move(-300, -700, 1, 1'b0, 1'b0, 4);
    run_move(500, 100, 5, 1'b0, 1'b0, 0);
    run_move(-1000, 1000, 0, 1'b1, 1'b0, 0);
    run_move(640, 0, 1, 1'b0, 1'b0, 0);
    check("queue_empty", hq.size() + vq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
